// File: rtl/fft_pkg.sv
// Shared FFT constants and types: frame geometry, complex word layout and the
// radix-8 twiddle table used by the column stages.
package fft_pkg;

    localparam int WW     = 64;
    localparam int NWORDS = 32;
    localparam int NMAC   = 4;
    localparam int NPHASE = 4;
    localparam int IDX_W  = 5;
    localparam int WPP    = NWORDS / NMAC;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        fp32_t re;
        fp32_t im;
    } cplx_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_SEND = 1'b1
    } rd_state_t;

    // W8^k = exp(-j*2*pi*k/8) in fp32
    localparam cplx_t TW8 [8] = '{
        '{32'h3F80_0000, 32'h0000_0000},
        '{32'h3F35_04F3, 32'hBF35_04F3},
        '{32'h0000_0000, 32'hBF80_0000},
        '{32'hBF35_04F3, 32'hBF35_04F3},
        '{32'hBF80_0000, 32'h0000_0000},
        '{32'hBF35_04F3, 32'h3F35_04F3},
        '{32'h0000_0000, 32'h3F80_0000},
        '{32'h3F35_04F3, 32'h3F35_04F3}
    };

    // Frame index of the word MAC m emits in half h of mac_sel phase p.
    function automatic logic [IDX_W-1:0] phase_word(input int m, input int h,
                                                    input logic [1:0] p);
        return IDX_W'(m * WPP + h * NPHASE + int'(p));
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage: eight words written per cycle from the phase-selected
// slices of the column bus, read back one word at a time without latency.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [1:0]             wr_phase,
    input  logic [NWORDS*WW-1:0]   wr_frame,
    input  logic [IDX_W-1:0]       rd_index,
    output logic [WW-1:0]          rd_data
);

    logic [WW-1:0] mem_q [NWORDS];
    logic [WW-1:0] mem_d [NWORDS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int m = 0; m < NMAC; m++) begin
                for (int h = 0; h < 2; h++) begin
                    mem_d[phase_word(m, h, wr_phase)] =
                        wr_frame[int'(phase_word(m, h, wr_phase)) * WW +: WW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_index];

endmodule

// File: rtl/fft_col_unloader.sv
// Captures the column stage's phase-multiplexed output into two ping-pong
// frame banks and streams completed frames out in index order.
module fft_col_unloader
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWORDS*WW-1:0]   in_frame,
    input  logic [1:0]             in_phase,
    input  logic                   in_valid,
    output logic [WW-1:0]          out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   frame_drop,
    output logic                   seq_err,
    output logic                   busy
);

    wr_state_t        wstate_q, wstate_d;
    logic [1:0]       expect_q, expect_d;
    logic             fill_bank_q, fill_bank_d;
    logic [1:0]       bank_busy_q, bank_busy_d;
    logic [1:0]       qcnt_q, qcnt_d;
    logic [1:0]       qent_q, qent_d;
    rd_state_t        rstate_q, rstate_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic          free_any, free_idx;
    logic          restart, claim, release_bank, push, pop, hs, last;
    logic          wr_go, wr_bank, wpos;
    logic          seq_err_c, drop_c;
    logic [1:0]    wr_en;
    logic [WW-1:0] rd_data [2];

    assign free_any = ~&bank_busy_q;
    assign free_idx = bank_busy_q[0];

    always_comb begin
        wstate_d     = wstate_q;
        expect_d     = expect_q;
        fill_bank_d  = fill_bank_q;
        restart      = 1'b0;
        claim        = 1'b0;
        release_bank = 1'b0;
        push         = 1'b0;
        wr_go        = 1'b0;
        wr_bank      = fill_bank_q;
        seq_err_c    = 1'b0;
        drop_c       = 1'b0;
        if (in_valid) begin
            unique case (wstate_q)
                W_IDLE: begin
                    if (in_phase == 2'd0) restart = 1'b1;
                    else                  seq_err_c = 1'b1;
                end
                W_FILL: begin
                    if (in_phase == expect_q) begin
                        wr_go = 1'b1;
                        if (in_phase == 2'd3) begin
                            push     = 1'b1;
                            wstate_d = W_IDLE;
                        end else begin
                            expect_d = expect_q + 2'd1;
                        end
                    end else begin
                        seq_err_c = 1'b1;
                        // A fresh phase 0 restarts the frame in the bank already held
                        if (in_phase == 2'd0) begin
                            wr_go    = 1'b1;
                            expect_d = 2'd1;
                        end else begin
                            release_bank = 1'b1;
                            wstate_d     = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (in_phase == 2'd3) begin
                        drop_c   = 1'b1;
                        wstate_d = W_IDLE;
                    end else if (in_phase == 2'd0) begin
                        restart = 1'b1;
                    end
                end
                default: wstate_d = W_IDLE;
            endcase
            // Free banks come from registered state, so a bank released this
            // cycle only becomes claimable on the next one.
            if (restart) begin
                if (free_any) begin
                    claim       = 1'b1;
                    fill_bank_d = free_idx;
                    wr_bank     = free_idx;
                    wr_go       = 1'b1;
                    wstate_d    = W_FILL;
                    expect_d    = 2'd1;
                end else begin
                    wstate_d = W_DROP;
                end
            end
        end
    end

    assign wr_en[0] = wr_go & ~wr_bank;
    assign wr_en[1] = wr_go &  wr_bank;

    assign out_valid = (rstate_q == R_SEND);
    assign hs        = out_valid & out_ready;
    assign last      = out_valid & (idx_q == IDX_W'(NWORDS - 1));
    assign pop       = hs & last;
    // Slot for a pushed entry: current depth, minus one if the head leaves now
    assign wpos      = qcnt_q[0] ^ pop;

    always_comb begin
        qcnt_d      = qcnt_q + 2'(push) - 2'(pop);
        qent_d      = qent_q;
        bank_busy_d = bank_busy_q;
        if (pop) begin
            qent_d[0]                = qent_q[1];
            bank_busy_d[qent_q[0]]   = 1'b0;
        end
        if (push)         qent_d[wpos]              = fill_bank_q;
        if (release_bank) bank_busy_d[fill_bank_q]  = 1'b0;
        if (claim)        bank_busy_d[free_idx]     = 1'b1;
    end

    always_comb begin
        rstate_d = rstate_q;
        idx_d    = idx_q;
        unique case (rstate_q)
            R_IDLE: begin
                if ((qcnt_q != 2'd0) || push) begin
                    rstate_d = R_SEND;
                    idx_d    = '0;
                end
            end
            R_SEND: begin
                if (hs) begin
                    if (last) begin
                        idx_d = '0;
                        if (qcnt_d == 2'd0) rstate_d = R_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q    <= W_IDLE;
            expect_q    <= 2'd0;
            fill_bank_q <= 1'b0;
            bank_busy_q <= 2'b00;
            qcnt_q      <= 2'd0;
            qent_q      <= 2'b00;
            rstate_q    <= R_IDLE;
            idx_q       <= '0;
        end else begin
            wstate_q    <= wstate_d;
            expect_q    <= expect_d;
            fill_bank_q <= fill_bank_d;
            bank_busy_q <= bank_busy_d;
            qcnt_q      <= qcnt_d;
            qent_q      <= qent_d;
            rstate_q    <= rstate_d;
            idx_q       <= idx_d;
        end
    end

    fft_frame_bank u_bank0 (
        .clk      (clk),
        .wr_en    (wr_en[0]),
        .wr_phase (in_phase),
        .wr_frame (in_frame),
        .rd_index (idx_q),
        .rd_data  (rd_data[0])
    );

    fft_frame_bank u_bank1 (
        .clk      (clk),
        .wr_en    (wr_en[1]),
        .wr_phase (in_phase),
        .wr_frame (in_frame),
        .rd_index (idx_q),
        .rd_data  (rd_data[1])
    );

    assign out_data   = out_valid ? rd_data[qent_q[0]] : '0;
    assign out_index  = idx_q;
    assign out_last   = last;
    assign seq_err    = seq_err_c & ~reset;
    assign frame_drop = drop_c & ~reset;
    assign busy       = (|bank_busy_q) | (wstate_q == W_FILL);

endmodule
